// File: rtl/sys_arr_edge_feeder_if.sv
// Handshake bundle for the systolic edge feeder: the tile-loader side
// (vec_*) and the per-PE operand side (lane_*).
interface sys_arr_edge_feeder_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 32
);
  logic                   vec_valid;
  logic                   vec_ready;
  logic [LANES*WIDTH-1:0] vec_dat;
  logic [LANES-1:0]       lane_valid;
  logic [LANES-1:0]       lane_ready;
  logic [LANES*WIDTH-1:0] lane_dat;

  // The feeder: accepts load beats, drives the edge PEs.
  modport master (
    input  vec_valid,
    input  vec_dat,
    input  lane_ready,
    output vec_ready,
    output lane_valid,
    output lane_dat
  );

  // The environment: tile loader plus the array edge.
  modport slave (
    output vec_valid,
    output vec_dat,
    output lane_ready,
    input  vec_ready,
    input  lane_valid,
    input  lane_dat
  );
endinterface

// File: rtl/sys_arr_edge_feeder.sv
// Transmit-side operand injector for one systolic-array edge. Buffers a tile
// of K operand vectors, then streams lane i with a one-beat skew behind lane
// i-1, so a stalled lane holds back every lane above it but none below.
module sys_arr_edge_feeder #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(DEPTH+1)-1:0]   len,
  sys_arr_edge_feeder_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DepthLen = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          len_q, len_d;
  logic [CW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          issued_q [LANES];
  logic [CW-1:0]          issued_d [LANES];
  logic                   vec_ready_q, vec_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [LANES*WIDTH-1:0] mem_q [DEPTH];

  logic [LANES-1:0]       lane_valid;
  logic [LANES*WIDTH-1:0] lane_dat;
  logic                   load_beat;
  logic                   all_issued;

  assign load_beat = bus.vec_valid & vec_ready_q;

  // Lane valid/data decoded from registers only (no ready->valid path).
  // issued[i-1] never exceeds len, so issued[i] < issued[i-1] already
  // implies issued[i] < len for the skewed lanes.
  always_comb begin
    lane_valid = '0;
    lane_dat   = '0;
    if (state_q == StStream) begin
      lane_valid[0] = issued_q[0] < len_q;
      for (int i = 1; i < LANES; i++) begin
        lane_valid[i] = issued_q[i] < issued_q[i-1];
      end
      for (int i = 0; i < LANES; i++) begin
        if (lane_valid[i]) begin
          lane_dat[i*WIDTH +: WIDTH] = mem_q[issued_q[i][AW-1:0]][i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Next-state: FSM transitions, pointers, per-lane issue counters, pulses.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    issued_d   = issued_q;
    err_d      = 1'b0;
    all_issued = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0 || len > DepthLen) begin
            err_d = 1'b1;
          end else begin
            len_d    = len;
            wr_ptr_d = '0;
            for (int i = 0; i < LANES; i++) issued_d[i] = '0;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        if (load_beat) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == len_q - 1'b1) state_d = StStream;
        end
      end
      StStream: begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_valid[i] && bus.lane_ready[i]) issued_d[i] = issued_q[i] + 1'b1;
          if (issued_d[i] != len_q) all_issued = 1'b0;
        end
        // Leave on the same edge as the final handshake.
        if (all_issued) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
    vec_ready_d = (state_d == StLoad);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < LANES; i++) issued_q[i] <= '0;
      vec_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      issued_q    <= issued_d;
      vec_ready_q <= vec_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Tile buffer: contents are don't-care across reset, so no reset here.
  always_ff @(posedge clk) begin
    if (load_beat) mem_q[wr_ptr_q[AW-1:0]] <= bus.vec_dat;
  end

  assign bus.vec_ready  = vec_ready_q;
  assign bus.lane_valid = lane_valid;
  assign bus.lane_dat   = lane_dat;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_sys_arr_edge_feeder.sv
// Bench for sys_arr_edge_feeder: table of tile starts (legal and illegal len),
// hand-written corner sequences, and random tiles checked every cycle against
// a per-lane issue-count model of the skewed stream.
module tb_sys_arr_edge_feeder;
  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] len_in;
  logic          busy;
  logic          done;
  logic          err;

  sys_arr_edge_feeder_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  sys_arr_edge_feeder #(.LANES(LANES), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len_in),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] tile_dat [DEPTH][LANES];

  typedef struct {
    int len;
    bit exp_err;
    int exp_stream;  // STREAM cycles with all lanes ready
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [LANES*WIDTH-1:0] act,
                     input logic [LANES*WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  task automatic check_idle(input string name);
    chk(name, {busy, done, err, bus.vec_ready, bus.lane_valid, bus.lane_dat}, '0);
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < DEPTH; k++)
      for (int i = 0; i < LANES; i++) tile_dat[k][i] = 32'h3F80_0000 + k * 16 + i;
  endtask

  task automatic fill_random();
    for (int k = 0; k < DEPTH; k++)
      for (int i = 0; i < LANES; i++) tile_dat[k][i] = $urandom();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Illegal len: err pulses for one cycle, nothing else moves.
  task automatic bad_start(input int l);
    start  = 1'b1;
    len_in = l[CW-1:0];
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", err, 1'b1);
    chk("err_quiet", {busy, bus.vec_ready, bus.lane_valid}, '0);
    @(negedge clk);
    chk("err_clear", {err, busy, bus.vec_ready, bus.lane_valid}, '0);
  endtask

  // One tile: load with optional gaps, stream under a ready pattern, compare
  // every cycle. rmode: 0 all ready, 1 random, 2 lane 1 stalled 5 cycles.
  task automatic run_tile(input int l, input int gap_pct, input int rmode, input bit glitch,
                          input int abort_at, input int exp_stream);
    int k;
    int guard;
    int cyc;
    int cnt [LANES];
    bit v;
    bit r;
    bit fin;
    bit all_in;
    logic [LANES-1:0]       ev;
    logic [LANES-1:0]       rdy;
    logic [LANES*WIDTH-1:0] ed;

    bus.lane_ready = '1;
    start  = 1'b1;
    len_in = l[CW-1:0];
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);

    k = 0;
    guard = 0;
    while (k < l && guard < 200) begin
      chk("load_ready", bus.vec_ready, 1'b1);
      chk("load_quiet", {done, err, bus.lane_valid}, '0);
      v = ($urandom_range(99) >= gap_pct);
      bus.vec_valid = v;
      for (int i = 0; i < LANES; i++) bus.vec_dat[i*WIDTH +: WIDTH] = tile_dat[k][i];
      if (glitch && guard == 1) begin
        start  = 1'b1;
        len_in = 4'd5;
      end
      r = bus.vec_ready;
      @(negedge clk);
      start = 1'b0;
      if (v && r) k++;
      guard++;
    end
    if (k < l) begin
      fail_now("load_timeout");
      reset_dut();
      return;
    end
    // Junk beats after the tile must be refused.
    bus.vec_valid = 1'b1;
    bus.vec_dat   = {LANES{32'hDEAD_BEEF}};

    for (int i = 0; i < LANES; i++) cnt[i] = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 400) begin
      all_in = 1'b1;
      for (int i = 0; i < LANES; i++) if (cnt[i] != l) all_in = 1'b0;
      if (all_in) begin
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b1);
        chk("done_lanes_idle", bus.lane_valid, '0);
        if (exp_stream >= 0) chk("stream_cycles", cyc, exp_stream);
        fin = 1'b1;
      end else begin
        ev = '0;
        ed = '0;
        for (int i = 0; i < LANES; i++) begin
          ev[i] = (cnt[i] < l) && (i == 0 || cnt[i] < cnt[(i == 0) ? 0 : i - 1]);
          if (ev[i]) ed[i*WIDTH +: WIDTH] = tile_dat[cnt[i]][i];
        end
        chk("lane_valid", bus.lane_valid, ev);
        chk("lane_dat", bus.lane_dat, ed);
        chk("stream_quiet", {bus.vec_ready, done, err}, '0);
        rdy = '1;
        if (rmode == 1) rdy = LANES'($urandom());
        if (rmode == 2 && cyc < 5) rdy[1] = 1'b0;
        bus.lane_ready = rdy;
        if (glitch && cyc == 1) begin
          start  = 1'b1;
          len_in = 4'd2;
        end
        if (cyc == abort_at) rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (rst) begin
          rst = 1'b0;
          check_idle("reset_mid_stream");
          for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("no_done_after_reset", {done, busy}, '0);
          end
          bus.vec_valid = 1'b0;
          return;
        end
        for (int i = 0; i < LANES; i++) if (ev[i] && rdy[i]) cnt[i]++;
        cyc++;
      end
    end
    bus.vec_valid = 1'b0;
    if (!fin) begin
      fail_now("stream_timeout");
      reset_dut();
      return;
    end
    @(negedge clk);
    chk("busy_drop", {busy, done}, '0);
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    len_in         = '0;
    bus.vec_valid  = 1'b0;
    bus.vec_dat    = '0;
    bus.lane_ready = '1;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle_after_reset");

    tbl[0] = '{len: 0,  exp_err: 1'b1, exp_stream: 0};
    tbl[1] = '{len: 9,  exp_err: 1'b1, exp_stream: 0};
    tbl[2] = '{len: 15, exp_err: 1'b1, exp_stream: 0};
    tbl[3] = '{len: 1,  exp_err: 1'b0, exp_stream: 4};
    tbl[4] = '{len: 3,  exp_err: 1'b0, exp_stream: 6};
    tbl[5] = '{len: 5,  exp_err: 1'b0, exp_stream: 8};
    tbl[6] = '{len: 8,  exp_err: 1'b0, exp_stream: 11};

    fill_pattern();
    foreach (tbl[t]) begin
      if (tbl[t].exp_err) bad_start(tbl[t].len);
      else run_tile(tbl[t].len, 0, 0, 1'b0, -1, tbl[t].exp_stream);
    end

    // Lane 1 stalled: lanes 2,3 held off, lane 0 unaffected.
    run_tile(3, 0, 2, 1'b0, -1, 10);
    // Full depth with load gaps.
    fill_random();
    run_tile(8, 40, 0, 1'b0, -1, 11);
    // Reset at STREAM cycle 2, then a fresh short tile.
    fill_pattern();
    run_tile(3, 0, 0, 1'b0, 2, -1);
    run_tile(2, 0, 0, 1'b0, -1, 5);
    // start during LOAD and STREAM is ignored.
    run_tile(4, 0, 0, 1'b1, -1, 7);

    for (int n = 0; n < 20; n++) begin
      fill_random();
      run_tile($urandom_range(8, 1), $urandom_range(50), 1, 1'b0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end
endmodule
